// File: rtl/mcu_block_sched.sv
// rtl/mcu_block_sched.sv - MCU-order block scheduler for the shared DCT pipeline
// Grants Y/Cb/Cr blocks of 64 beats in JPEG MCU interleave order and tags them with a component id.
module mcu_block_sched #(
   parameter int DATA_WIDTH    = 8,
   parameter int MCU_CNT_WIDTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [1:0]               mode_i,
   input  logic [DATA_WIDTH-1:0]    y_tdata_i,
   input  logic                     y_tvalid_i,
   input  logic                     y_tlast_i,
   output logic                     y_tready_o,
   input  logic [DATA_WIDTH-1:0]    cb_tdata_i,
   input  logic                     cb_tvalid_i,
   input  logic                     cb_tlast_i,
   output logic                     cb_tready_o,
   input  logic [DATA_WIDTH-1:0]    cr_tdata_i,
   input  logic                     cr_tvalid_i,
   input  logic                     cr_tlast_i,
   output logic                     cr_tready_o,
   output logic [DATA_WIDTH-1:0]    blk_tdata_o,
   output logic                     blk_tvalid_o,
   output logic                     blk_tlast_o,
   input  logic                     blk_tready_i,
   output logic [1:0]               comp_id_o,
   output logic                     mcu_done_o,
   output logic [MCU_CNT_WIDTH-1:0] mcu_cnt_o,
   output logic                     err_o
);

   typedef enum logic [1:0] {
      S_Y  = 2'd0,
      S_CB = 2'd1,
      S_CR = 2'd2
   } state_e;

   state_e                   state_q, state_d;
   logic [1:0]               blk_cnt_q, blk_cnt_d;
   logic [5:0]               px_cnt_q, px_cnt_d;
   logic [1:0]               mode_q;
   logic                     run_q;
   logic [1:0]               comp_id_q;
   logic                     mcu_done_q;
   logic [MCU_CNT_WIDTH-1:0] mcu_cnt_q;
   logic                     err_q, err_d;

   logic [DATA_WIDTH-1:0]    src_tdata;
   logic                     src_tvalid;
   logic                     src_tlast;
   logic                     hs;
   logic                     last_px;
   logic                     mcu_end;
   logic [1:0]               y_per_mcu_m1;

   // run_q holds all grants off until the sampling mode has been latched
   always_comb begin
      src_tdata  = y_tdata_i;
      src_tvalid = y_tvalid_i;
      src_tlast  = y_tlast_i;
      case (state_q)
         S_CB: begin
            src_tdata  = cb_tdata_i;
            src_tvalid = cb_tvalid_i;
            src_tlast  = cb_tlast_i;
         end
         S_CR: begin
            src_tdata  = cr_tdata_i;
            src_tvalid = cr_tvalid_i;
            src_tlast  = cr_tlast_i;
         end
         default: ;
      endcase
      last_px      = (px_cnt_q == 6'd63);
      blk_tdata_o  = src_tdata;
      blk_tvalid_o = run_q & src_tvalid;
      blk_tlast_o  = last_px;
      y_tready_o   = run_q & blk_tready_i & (state_q == S_Y);
      cb_tready_o  = run_q & blk_tready_i & (state_q == S_CB);
      cr_tready_o  = run_q & blk_tready_i & (state_q == S_CR);
      hs           = blk_tvalid_o & blk_tready_i;
   end

   always_comb begin
      case (mode_q)
         2'b10:   y_per_mcu_m1 = 2'd1;
         2'b11:   y_per_mcu_m1 = 2'd3;
         default: y_per_mcu_m1 = 2'd0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      blk_cnt_d = blk_cnt_q;
      px_cnt_d  = px_cnt_q;
      mcu_end   = 1'b0;
      err_d     = err_q | (hs & (src_tlast != last_px));
      if (hs) begin
         px_cnt_d = px_cnt_q + 6'd1;
         if (last_px) begin
            case (state_q)
               S_Y: begin
                  if (blk_cnt_q == y_per_mcu_m1) begin
                     blk_cnt_d = 2'd0;
                     if (mode_q == 2'b00) begin
                        mcu_end = 1'b1;
                     end else begin
                        state_d = S_CB;
                     end
                  end else begin
                     blk_cnt_d = blk_cnt_q + 2'd1;
                  end
               end
               S_CB: state_d = S_CR;
               default: begin
                  state_d = S_Y;
                  mcu_end = 1'b1;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= S_Y;
         blk_cnt_q  <= 2'd0;
         px_cnt_q   <= 6'd0;
         mode_q     <= 2'b00;
         run_q      <= 1'b0;
         comp_id_q  <= 2'd0;
         mcu_done_q <= 1'b0;
         mcu_cnt_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         blk_cnt_q  <= blk_cnt_d;
         px_cnt_q   <= px_cnt_d;
         run_q      <= 1'b1;
         // mode only changes at an MCU boundary (or the first clock out of reset)
         if (!run_q || mcu_end) begin
            mode_q <= mode_i;
         end
         comp_id_q  <= state_d;
         mcu_done_q <= mcu_end;
         mcu_cnt_q  <= mcu_cnt_q + MCU_CNT_WIDTH'(mcu_end);
         err_q      <= err_d;
      end
   end

   assign comp_id_o  = comp_id_q;
   assign mcu_done_o = mcu_done_q;
   assign mcu_cnt_o  = mcu_cnt_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_mcu_block_sched.sv
// tb/tb_mcu_block_sched.sv - self-checking bench for mcu_block_sched
// Vector table of mode runs plus hand sequences for mode change, tlast error and mid-block reset.
module tb_mcu_block_sched;

   logic        clk = 1'b0;
   logic        rst_n_i;
   logic [1:0]  mode_i;
   logic [7:0]  y_tdata_i, cb_tdata_i, cr_tdata_i;
   logic        y_tvalid_i, cb_tvalid_i, cr_tvalid_i;
   logic        y_tlast_i, cb_tlast_i, cr_tlast_i;
   logic        y_tready_o, cb_tready_o, cr_tready_o;
   logic [7:0]  blk_tdata_o;
   logic        blk_tvalid_o, blk_tlast_o, blk_tready_i;
   logic [1:0]  comp_id_o;
   logic        mcu_done_o;
   logic [15:0] mcu_cnt_o;
   logic        err_o;

   always #5 clk = ~clk;

   mcu_block_sched #(.DATA_WIDTH(8), .MCU_CNT_WIDTH(16)) dut (
      .clk_i(clk), .rst_n_i(rst_n_i), .mode_i(mode_i),
      .y_tdata_i(y_tdata_i), .y_tvalid_i(y_tvalid_i), .y_tlast_i(y_tlast_i), .y_tready_o(y_tready_o),
      .cb_tdata_i(cb_tdata_i), .cb_tvalid_i(cb_tvalid_i), .cb_tlast_i(cb_tlast_i), .cb_tready_o(cb_tready_o),
      .cr_tdata_i(cr_tdata_i), .cr_tvalid_i(cr_tvalid_i), .cr_tlast_i(cr_tlast_i), .cr_tready_o(cr_tready_o),
      .blk_tdata_o(blk_tdata_o), .blk_tvalid_o(blk_tvalid_o), .blk_tlast_o(blk_tlast_o),
      .blk_tready_i(blk_tready_i), .comp_id_o(comp_id_o), .mcu_done_o(mcu_done_o),
      .mcu_cnt_o(mcu_cnt_o), .err_o(err_o)
   );

   typedef struct {
      logic [1:0] comp;
      logic [7:0] data;
      logic       last;
      logic       mcu_end;
   } exp_t;

   typedef struct {
      logic [1:0] mode;
      int         mcus;
      bit         rnd;
      int         exp_beats;
      int         exp_mcu;
   } vec_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_n[3];
   int   src_n[3];
   int   pops, pulses;
   bit   rnd, inj;
   logic pulse_exp, err_exp;
   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] src_data(input int c, input int n);
      logic [7:0] b;
      b = n[7:0];
      case (c)
         0:       return b;
         1:       return b ^ 8'h5A;
         default: return b + 8'h80;
      endcase
   endfunction

   task automatic push_block(input int c, input bit mcu_last);
      exp_t e;
      for (int i = 0; i < 64; i++) begin
         e.comp    = 2'(c);
         e.data    = src_data(c, exp_n[c]);
         e.last    = (i == 63);
         e.mcu_end = mcu_last && (i == 63);
         exp_n[c]++;
         q.push_back(e);
      end
   endtask

   task automatic push_mcu(input logic [1:0] m);
      int ny;
      ny = (m == 2'b11) ? 4 : (m == 2'b10) ? 2 : 1;
      for (int b = 0; b < ny; b++) push_block(0, (m == 2'b00) && (b == ny - 1));
      if (m != 2'b00) begin
         push_block(1, 1'b0);
         push_block(2, 1'b1);
      end
   endtask

   task automatic drive();
      y_tdata_i    = src_data(0, src_n[0]);
      cb_tdata_i   = src_data(1, src_n[1]);
      cr_tdata_i   = src_data(2, src_n[2]);
      y_tlast_i    = (src_n[0] % 64 == 63) || (inj && src_n[0] == 31);
      cb_tlast_i   = (src_n[1] % 64 == 63);
      cr_tlast_i   = (src_n[2] % 64 == 63);
      blk_tready_i = (q.size() != 0) && (rnd ? ($urandom_range(1) == 1) : 1'b1);
   endtask

   task automatic cycle();
      exp_t       e;
      logic [2:0] exp_rdy;
      logic       pulse_nx, err_nx, slast;
      @(negedge clk);
      exp_rdy = 3'b000;
      if (q.size() != 0 && blk_tready_i) exp_rdy = 3'b001 << q[0].comp;
      chk("ctl", {cr_tready_o, cb_tready_o, y_tready_o, mcu_done_o, err_o},
          {exp_rdy, pulse_exp, err_exp});
      if (mcu_done_o) pulses++;
      pulse_nx = 1'b0;
      err_nx   = err_exp;
      if (blk_tvalid_o && blk_tready_i) begin
         if (q.size() == 0) begin
            chk("extra_beat", 32'(blk_tvalid_o & blk_tready_i), 32'd0);
         end else begin
            e = q.pop_front();
            chk("beat", {comp_id_o, blk_tlast_o, blk_tdata_o}, {e.comp, e.last, e.data});
            pulse_nx = e.mcu_end;
            slast = (e.comp == 2'd0) ? y_tlast_i : (e.comp == 2'd1) ? cb_tlast_i : cr_tlast_i;
            if (slast !== e.last) err_nx = 1'b1;
         end
         pops++;
      end
      if (y_tready_o && y_tvalid_i) src_n[0]++;
      if (cb_tready_o && cb_tvalid_i) src_n[1]++;
      if (cr_tready_o && cr_tvalid_i) src_n[2]++;
      @(posedge clk);
      #1;
      pulse_exp = pulse_nx;
      err_exp   = err_nx;
      drive();
   endtask

   task automatic run_until(input int target, input int budget);
      int n;
      n = 0;
      drive();
      while (q.size() != 0 && pops < target && n < budget) begin
         cycle();
         n++;
      end
      chk("progress", 32'(q.size() == 0 || pops >= target), 32'd1);
   endtask

   task automatic do_reset(input logic [1:0] m);
      rst_n_i      = 1'b0;
      blk_tready_i = 1'b0;
      mode_i       = m;
      #1;
      chk("reset_state", {blk_tvalid_o, cr_tready_o, cb_tready_o, y_tready_o, mcu_done_o,
                          err_o, comp_id_o, mcu_cnt_o}, 32'd0);
      q.delete();
      for (int i = 0; i < 3; i++) begin
         exp_n[i] = 0;
         src_n[i] = 0;
      end
      pops      = 0;
      pulses    = 0;
      pulse_exp = 1'b0;
      err_exp   = 1'b0;
      drive();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n_i = 1'b1;
      @(posedge clk);
      #1;
      drive();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{mode: 2'b11, mcus: 1, rnd: 1'b0, exp_beats: 384, exp_mcu: 1};
      vecs[1] = '{mode: 2'b00, mcus: 3, rnd: 1'b0, exp_beats: 192, exp_mcu: 3};
      vecs[2] = '{mode: 2'b10, mcus: 2, rnd: 1'b1, exp_beats: 512, exp_mcu: 2};
      vecs[3] = '{mode: 2'b01, mcus: 2, rnd: 1'b1, exp_beats: 384, exp_mcu: 2};
      vecs[4] = '{mode: 2'b11, mcus: 1, rnd: 1'b1, exp_beats: 384, exp_mcu: 1};

      y_tvalid_i  = 1'b1;
      cb_tvalid_i = 1'b1;
      cr_tvalid_i = 1'b1;
      rnd = 1'b0;
      inj = 1'b0;

      for (int v = 0; v < 5; v++) begin
         rnd = vecs[v].rnd;
         do_reset(vecs[v].mode);
         for (int m = 0; m < vecs[v].mcus; m++) push_mcu(vecs[v].mode);
         run_until(1 << 30, 20000);
         repeat (2) cycle();
         chk("beats", 32'(pops), 32'(vecs[v].exp_beats));
         chk("mcu_cnt", 32'(mcu_cnt_o), 32'(vecs[v].exp_mcu));
         chk("pulses", 32'(pulses), 32'(vecs[v].exp_mcu));
         chk("err_clear", 32'(err_o), 32'd0);
      end

      // mode change mid-MCU: 4:2:0 finishes, then 4:4:4
      rnd = 1'b0;
      do_reset(2'b11);
      push_mcu(2'b11);
      push_mcu(2'b01);
      run_until(100, 2000);
      mode_i = 2'b01;
      run_until(1 << 30, 2000);
      repeat (2) cycle();
      chk("mode_chg_beats", 32'(pops), 32'd576);
      chk("mode_chg_cnt", 32'(mcu_cnt_o), 32'd2);

      // Y tlast on beat 31: sticky error, schedule unaffected
      do_reset(2'b01);
      inj = 1'b1;
      push_mcu(2'b01);
      push_mcu(2'b01);
      run_until(1 << 30, 2000);
      repeat (2) cycle();
      inj = 1'b0;
      chk("err_sticky", 32'(err_o), 32'd1);
      chk("err_cnt", 32'(mcu_cnt_o), 32'd2);

      // reset at beat 200 of a 4:2:0 MCU, then a full MCU from Y beat 0
      do_reset(2'b11);
      push_mcu(2'b11);
      run_until(200, 1000);
      chk("pre_reset_beats", 32'(pops), 32'd200);
      #2;
      do_reset(2'b11);
      push_mcu(2'b11);
      run_until(1 << 30, 1000);
      repeat (2) cycle();
      chk("post_reset_beats", 32'(pops), 32'd384);
      chk("post_reset_cnt", 32'(mcu_cnt_o), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
